train_track_model: RTL and testbench

Behavioural plant model of the two-train track, the other end of the `TrainState` controller interface. It consumes the controller's switch and direction commands (`SW`, `DA`, `DB`) and produces the sensor vector `SR` that feeds back into the controller. Each train moves step-wise around its own 16-position ring, and both rings share one junction block. With this model, controller benches run closed-loop, and the model flags any collision in the shared block.

---
 rtl/train_pkg.sv | 22 ++
 rtl/train_mover.sv | 49 ++++
 rtl/train_track_model.sv | 58 +++++
 tb/tb_train_track_model.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/train_pkg.sv
// Shared direction codes, ring geometry and block-membership helper for the track model.
package train_pkg;

  typedef enum logic [1:0] {
    DIR_STOP  = 2'b00,
    DIR_FWD   = 2'b01,
    DIR_REV   = 2'b10,
    DIR_BRAKE = 2'b11
  } dir_e;

  localparam logic [3:0] POS_JUNC_ENTRY = 4'd11;
  localparam logic [3:0] POS_BLOCK_LO   = 4'd12;
  localparam logic [3:0] POS_BLOCK_HI   = 4'd15;
  localparam logic [3:0] POS_EXIT       = 4'd0;
  localparam int         RING_LEN       = 16;

  // Positions 12..15 form the shared junction block; 15 is the top of the 4-bit ring.
  function automatic logic in_block(input logic [3:0] p);
    return p >= POS_BLOCK_LO;
  endfunction

endpackage

// File: rtl/train_mover.sv
// One train: step counter plus ring position, with gated entries into the junction block.
module train_mover
  import train_pkg::*;
#(
  parameter int         STEP_CYCLES = 4,
  parameter logic [3:0] START       = 4'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dir,
  input  logic       fwd_gate,
  input  logic       rev_gate,
  output logic [3:0] pos
);

  localparam int            CW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          fwd;
  logic          rev;
  logic          permit;

  always_comb begin
    fwd    = (dir == DIR_FWD);
    rev    = (dir == DIR_REV);
    permit = 1'b1;
    if (fwd && pos == POS_JUNC_ENTRY) permit = fwd_gate;
    if (rev && pos == POS_EXIT)       permit = rev_gate;
  end

  // A closed gate parks the counter at terminal count so the move fires on the first open edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= START;
      cnt <= '0;
    end else if (fwd || rev) begin
      if (cnt == TERM) begin
        if (permit) begin
          pos <= fwd ? pos + 4'd1 : pos - 4'd1;
          cnt <= '0;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/train_track_model.sv
// Two-train track plant: movers for A and B, sensor decode, and a sticky collision flag.
module train_track_model
  import train_pkg::*;
#(
  parameter int STEP_CYCLES = 4,
  parameter int START_A     = 2,
  parameter int START_B     = 6
) (
  input  logic       Clock,
  input  logic       RESET,
  input  logic [3:1] SW,
  input  logic [1:0] DA,
  input  logic [1:0] DB,
  output logic [4:1] SR,
  output logic       COLLIDE,
  output logic [3:0] POSA,
  output logic [3:0] POSB
);

  train_mover #(
    .STEP_CYCLES(STEP_CYCLES),
    .START      (4'(START_A))
  ) u_mover_a (
    .clk     (Clock),
    .rst     (RESET),
    .dir     (DA),
    .fwd_gate(SW[1]),
    .rev_gate(SW[3]),
    .pos     (POSA)
  );

  train_mover #(
    .STEP_CYCLES(STEP_CYCLES),
    .START      (4'(START_B))
  ) u_mover_b (
    .clk     (Clock),
    .rst     (RESET),
    .dir     (DB),
    .fwd_gate(SW[2]),
    .rev_gate(SW[3]),
    .pos     (POSB)
  );

  assign SR[1] = (POSA == POS_JUNC_ENTRY);
  assign SR[2] = (POSB == POS_JUNC_ENTRY);
  assign SR[3] = in_block(POSA) || in_block(POSB);
  assign SR[4] = (POSA == POS_EXIT) || (POSB == POS_EXIT);

  // Registered off the positions, so it trails the overlapping move by one edge.
  always_ff @(posedge Clock) begin
    if (RESET) begin
      COLLIDE <= 1'b0;
    end else if (in_block(POSA) && in_block(POSB)) begin
      COLLIDE <= 1'b1;
    end
  end

endmodule

// File: tb/tb_train_track_model.sv
// Directed closed-loop stimulus for train_track_model with a queued expected-state scoreboard.
module tb_train_track_model;

  logic       Clock = 1'b0;
  logic       RESET;
  logic [3:1] SW;
  logic [1:0] DA;
  logic [1:0] DB;
  logic [4:1] SR;
  logic       COLLIDE;
  logic [3:0] POSA;
  logic [3:0] POSB;

  always #5 Clock = ~Clock;

  train_track_model dut (
    .Clock  (Clock),
    .RESET  (RESET),
    .SW     (SW),
    .DA     (DA),
    .DB     (DB),
    .SR     (SR),
    .COLLIDE(COLLIDE),
    .POSA   (POSA),
    .POSB   (POSB)
  );

  typedef struct {
    logic [3:0] posa;
    logic [3:0] posb;
    logic [4:1] sr;
    logic       col;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fails  = 0;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [3:0] pa, input logic [3:0] pb,
                          input logic [4:1] sr, input logic col);
    exp_t e;
    e.posa = pa;
    e.posb = pb;
    e.sr   = sr;
    e.col  = col;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    n_checks++;
    assert (exp_q.size() > 0) else begin
      n_fails++;
      $error("FAIL scoreboard_empty observed=0 expected>0");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      assert (POSA === e.posa) else begin
        n_fails++;
        $error("FAIL %s.POSA observed=%0d expected=%0d", t, POSA, e.posa);
      end
      n_checks++;
      assert (POSB === e.posb) else begin
        n_fails++;
        $error("FAIL %s.POSB observed=%0d expected=%0d", t, POSB, e.posb);
      end
      n_checks++;
      assert (SR === e.sr) else begin
        n_fails++;
        $error("FAIL %s.SR observed=%b expected=%b", t, SR, e.sr);
      end
      n_checks++;
      assert (COLLIDE === e.col) else begin
        n_fails++;
        $error("FAIL %s.COLLIDE observed=%b expected=%b", t, COLLIDE, e.col);
      end
    end
  endtask

  // Queue the expectation, run n edges, then compare against the DUT.
  task automatic run_chk(input int n, input string tag, input logic [3:0] pa,
                         input logic [3:0] pb, input logic [4:1] sr, input logic col);
    push_exp(tag, pa, pb, sr, col);
    step(n);
    pop_check();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    SW    = 3'b000;
    DA    = 2'b00;
    DB    = 2'b00;
    #2;

    // Reset values and idle hold.
    push_exp("reset", 4'd2, 4'd6, 4'b0000, 1'b0);
    do_reset();
    pop_check();
    run_chk(20, "idle_hold", 4'd2, 4'd6, 4'b0000, 1'b0);

    // A forward into the junction, stalled on SW[1].
    DA = 2'b01;
    run_chk(3,  "fwd_pre_first", 4'd2,  4'd6, 4'b0000, 1'b0);
    run_chk(1,  "fwd_first",     4'd3,  4'd6, 4'b0000, 1'b0);
    run_chk(32, "fwd_at_11",     4'd11, 4'd6, 4'b0001, 1'b0);
    run_chk(12, "fwd_stall",     4'd11, 4'd6, 4'b0001, 1'b0);
    SW = 3'b001;
    run_chk(1,  "fwd_gate_open", 4'd12, 4'd6, 4'b0100, 1'b0);

    // A reverse to 0, stalled on SW[3], then through 15 and down the block.
    SW = 3'b000;
    DA = 2'b00;
    do_reset();
    DA = 2'b10;
    run_chk(8, "rev_at_0",     4'd0,  4'd6, 4'b1000, 1'b0);
    run_chk(5, "rev_stall",    4'd0,  4'd6, 4'b1000, 1'b0);
    SW = 3'b100;
    run_chk(1, "rev_gate_open", 4'd15, 4'd6, 4'b0100, 1'b0);
    SW = 3'b000;
    run_chk(4, "rev_in_block", 4'd14, 4'd6, 4'b0100, 1'b0);

    // Stop holds the count; resume moves two edges later.
    DA = 2'b00;
    do_reset();
    DA = 2'b01;
    step(2);
    DA = 2'b11;
    run_chk(10, "stop_hold",   4'd2, 4'd6, 4'b0000, 1'b0);
    DA = 2'b01;
    run_chk(1,  "resume_cnt3", 4'd2, 4'd6, 4'b0000, 1'b0);
    run_chk(1,  "resume_move", 4'd3, 4'd6, 4'b0000, 1'b0);

    // Direction toggle mid-count keeps the count.
    step(2);
    DA = 2'b10;
    run_chk(1, "toggle_cnt3", 4'd3, 4'd6, 4'b0000, 1'b0);
    run_chk(1, "toggle_move", 4'd2, 4'd6, 4'b0000, 1'b0);

    // Collision: B delayed 16 edges so both enter the block on the same edge.
    DA = 2'b00;
    do_reset();
    SW = 3'b011;
    DA = 2'b01;
    run_chk(16, "col_b_held",  4'd6,  4'd6,  4'b0000, 1'b0);
    DB = 2'b01;
    run_chk(23, "col_both_11", 4'd11, 4'd11, 4'b0011, 1'b0);
    run_chk(1,  "col_entry",   4'd12, 4'd12, 4'b0100, 1'b0);
    run_chk(1,  "col_set",     4'd12, 4'd12, 4'b0100, 1'b1);
    run_chk(15, "col_exit_0",  4'd0,  4'd0,  4'b1000, 1'b1);
    run_chk(20, "col_sticky",  4'd5,  4'd5,  4'b0000, 1'b1);

    // Reset while both are in the block.
    RESET = 1'b1;
    DA = 2'b00;
    DB = 2'b00;
    step(1);
    RESET = 1'b0;
    DA = 2'b01;
    step(16);
    DB = 2'b01;
    run_chk(28, "col_again",   4'd13, 4'd13, 4'b0100, 1'b1);
    RESET = 1'b1;
    run_chk(1,  "mid_block_reset", 4'd2, 4'd6, 4'b0000, 1'b0);
    RESET = 1'b0;
    DA = 2'b00;
    DB = 2'b00;
    run_chk(4,  "post_reset_idle", 4'd2, 4'd6, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
